// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bundle: MEM-side inputs, pipeline control
// and the registered write-back outputs.
interface mem_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              flush;
    logic              stall_mem;
    logic              stall_wb;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_wd;
    logic              mem_wreg;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_whilo;
    logic [DATA_W-1:0] mem_hi;
    logic [DATA_W-1:0] mem_lo;
    logic              mem_llbit_we;
    logic              mem_llbit_value;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_whilo;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              wb_llbit_we;
    logic              wb_llbit_value;
    logic [CNT_W-1:0]  retire_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output flush, stall_mem, stall_wb,
        output mem_valid, mem_wd, mem_wreg,
        output mem_wdata, mem_whilo,
        output mem_hi, mem_lo,
        output mem_llbit_we, mem_llbit_value,
        input  wb_valid, wb_wd, wb_wreg,
        input  wb_wdata, wb_whilo,
        input  wb_hi, wb_lo,
        input  wb_llbit_we, wb_llbit_value,
        input  retire_cnt, bubble_cnt
    );

    modport slave (
        input  flush, stall_mem, stall_wb,
        input  mem_valid, mem_wd, mem_wreg,
        input  mem_wdata, mem_whilo,
        input  mem_hi, mem_lo,
        input  mem_llbit_we, mem_llbit_value,
        output wb_valid, wb_wd, wb_wreg,
        output wb_wdata, wb_whilo,
        output wb_hi, wb_lo,
        output wb_llbit_we, wb_llbit_value,
        output retire_cnt, bubble_cnt
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: GPR, HI/LO and LLbit write-back
// with stall/bubble/flush control and retire/bubble counters.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input logic           clk,
    input logic           rst,
    mem_wb_stage_if.slave bus
);

    logic              valid_q;
    logic [ADDR_W-1:0] wd_q;
    logic              wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic              whilo_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              llwe_q;
    logic              llval_q;
    logic [CNT_W-1:0]  retire_q;
    logic [CNT_W-1:0]  bubble_q;

    logic              do_load;
    logic              do_clear;
    logic              do_bubble;
    logic              wd_nz;

    // Decode the cycle action; stall_wb holds even when
    // stall_mem is low, so that case never loads.
    always_comb begin
        do_clear  = 1'b0;
        do_bubble = 1'b0;
        do_load   = 1'b0;
        if (bus.flush) begin
            do_clear = 1'b1;
        end else if (!bus.stall_wb) begin
            if (bus.stall_mem) begin
                do_clear  = 1'b1;
                do_bubble = 1'b1;
            end else begin
                do_load = 1'b1;
            end
        end
    end

    assign wd_nz = (bus.mem_wd != '0);

    // Payload register: clear, capture or hold.
    always_ff @(posedge clk) begin
        if (rst || do_clear) begin
            valid_q <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            llwe_q  <= 1'b0;
            llval_q <= 1'b0;
        end else if (do_load) begin
            valid_q <= bus.mem_valid;
            wd_q    <= bus.mem_wd;
            wreg_q  <= bus.mem_valid
                     & bus.mem_wreg
                     & wd_nz;
            wdata_q <= bus.mem_wdata;
            whilo_q <= bus.mem_valid
                     & bus.mem_whilo;
            hi_q    <= bus.mem_hi;
            lo_q    <= bus.mem_lo;
            llwe_q  <= bus.mem_valid
                     & bus.mem_llbit_we;
            llval_q <= bus.mem_llbit_value;
        end
    end

    // Saturating counters; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
            bubble_q <= '0;
        end else begin
            if (do_load && bus.mem_valid
                && retire_q != '1) begin
                retire_q <= retire_q + 1'b1;
            end
            if (do_bubble && bubble_q != '1) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    assign bus.wb_valid       = valid_q;
    assign bus.wb_wd          = wd_q;
    assign bus.wb_wreg        = wreg_q;
    assign bus.wb_wdata       = wdata_q;
    assign bus.wb_whilo       = whilo_q;
    assign bus.wb_hi          = hi_q;
    assign bus.wb_lo          = lo_q;
    assign bus.wb_llbit_we    = llwe_q;
    assign bus.wb_llbit_value = llval_q;
    assign bus.retire_cnt     = retire_q;
    assign bus.bubble_cnt     = bubble_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed plan steps plus random
// traffic against a behavioural model; a CNT_W=4 copy checks saturation.
module tb_mem_wb_stage;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mem_wb_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
    mem_wb_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

    mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // Small copy sees identical stimulus.
    assign bus4.flush           = bus.flush;
    assign bus4.stall_mem       = bus.stall_mem;
    assign bus4.stall_wb        = bus.stall_wb;
    assign bus4.mem_valid       = bus.mem_valid;
    assign bus4.mem_wd          = bus.mem_wd;
    assign bus4.mem_wreg        = bus.mem_wreg;
    assign bus4.mem_wdata       = bus.mem_wdata;
    assign bus4.mem_whilo       = bus.mem_whilo;
    assign bus4.mem_hi          = bus.mem_hi;
    assign bus4.mem_lo          = bus.mem_lo;
    assign bus4.mem_llbit_we    = bus.mem_llbit_we;
    assign bus4.mem_llbit_value = bus.mem_llbit_value;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected WB contents and raw (unsaturated) event counts.
    logic        e_valid;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_llwe;
    logic        e_llval;
    longint      n_ret;
    longint      n_bub;

    function automatic longint sat(longint n, longint mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mem(
        input logic v, input logic [4:0] wd, input logic wr,
        input logic [31:0] wdat, input logic whl,
        input logic [31:0] hi, input logic [31:0] lo,
        input logic llwe, input logic llv);
        bus.mem_valid       = v;
        bus.mem_wd          = wd;
        bus.mem_wreg        = wr;
        bus.mem_wdata       = wdat;
        bus.mem_whilo       = whl;
        bus.mem_hi          = hi;
        bus.mem_lo          = lo;
        bus.mem_llbit_we    = llwe;
        bus.mem_llbit_value = llv;
    endtask

    task automatic set_ctl(input logic r, input logic f,
                           input logic sm, input logic sw);
        rst           = r;
        bus.flush     = f;
        bus.stall_mem = sm;
        bus.stall_wb  = sw;
    endtask

    task automatic rand_mem();
        set_mem($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                1'($urandom), $urandom, 1'($urandom), $urandom,
                $urandom, 1'($urandom), 1'($urandom));
    endtask

    task automatic clear_exp();
        e_valid = 0; e_wd = 0; e_wreg = 0; e_wdata = 0;
        e_whilo = 0; e_hi = 0; e_lo = 0;
        e_llwe = 0; e_llval = 0;
    endtask

    task automatic check_all();
        chk("valid", bus.wb_valid, e_valid);
        chk("wd", bus.wb_wd, e_wd);
        chk("wreg", bus.wb_wreg, e_wreg);
        chk("wdata", bus.wb_wdata, e_wdata);
        chk("whilo", bus.wb_whilo, e_whilo);
        chk("hi", bus.wb_hi, e_hi);
        chk("lo", bus.wb_lo, e_lo);
        chk("llwe", bus.wb_llbit_we, e_llwe);
        chk("llval", bus.wb_llbit_value, e_llval);
        chk("retire", bus.retire_cnt, 64'(sat(n_ret, 64'hFFFF_FFFF)));
        chk("bubble", bus.bubble_cnt, 64'(sat(n_bub, 64'hFFFF_FFFF)));
        chk("retire4", bus4.retire_cnt, 64'(sat(n_ret, 15)));
        chk("bubble4", bus4.bubble_cnt, 64'(sat(n_bub, 15)));
        chk("valid4", bus4.wb_valid, e_valid);
        chk("wdata4", bus4.wb_wdata, e_wdata);
    endtask

    // One clock: apply the priority rules to the current inputs,
    // advance, then compare just after the edge.
    task automatic tick();
        if (rst) begin
            clear_exp();
            n_ret = 0;
            n_bub = 0;
        end else if (bus.flush) begin
            clear_exp();
        end else if (bus.stall_wb) begin
            // hold
        end else if (bus.stall_mem) begin
            clear_exp();
            n_bub++;
        end else begin
            e_valid = bus.mem_valid;
            e_wd    = bus.mem_wd;
            e_wreg  = bus.mem_valid && bus.mem_wreg
                      && bus.mem_wd != 0;
            e_wdata = bus.mem_wdata;
            e_whilo = bus.mem_valid && bus.mem_whilo;
            e_hi    = bus.mem_hi;
            e_lo    = bus.mem_lo;
            e_llwe  = bus.mem_valid && bus.mem_llbit_we;
            e_llval = bus.mem_llbit_value;
            if (bus.mem_valid) n_ret++;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        n_ret  = 0;
        n_bub  = 0;
        clear_exp();

        // Reset with random MEM inputs
        set_ctl(1, 0, 0, 0);
        rand_mem();
        tick();
        rand_mem();
        tick();
        chk("rst_valid", bus.wb_valid, 0);
        chk("rst_wdata", bus.wb_wdata, 0);
        chk("rst_retire", bus.retire_cnt, 0);
        chk("rst_bubble", bus.bubble_cnt, 0);

        // Normal load
        set_ctl(0, 0, 0, 0);
        set_mem(1, 5'd3, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        tick();
        chk("load_wd", bus.wb_wd, 3);
        chk("load_wreg", bus.wb_wreg, 1);
        chk("load_wdata", bus.wb_wdata, 32'hDEADBEEF);
        chk("load_valid", bus.wb_valid, 1);
        chk("load_retire", bus.retire_cnt, 1);

        // $zero suppression with HI/LO
        set_mem(1, 5'd0, 1, 32'h55, 1, 32'h1, 32'h2, 1, 1);
        tick();
        chk("zero_wreg", bus.wb_wreg, 0);
        chk("zero_whilo", bus.wb_whilo, 1);
        chk("zero_hi", bus.wb_hi, 1);
        chk("zero_lo", bus.wb_lo, 2);
        chk("zero_llwe", bus.wb_llbit_we, 1);

        // Same with mem_valid=0
        set_mem(0, 5'd0, 1, 32'h55, 1, 32'h1, 32'h2, 1, 1);
        tick();
        chk("inv_wreg", bus.wb_wreg, 0);
        chk("inv_whilo", bus.wb_whilo, 0);
        chk("inv_llwe", bus.wb_llbit_we, 0);
        chk("inv_retire", bus.retire_cnt, 2);

        // Stall sequence: A, hold x3, bubble, B
        set_mem(1, 5'd7, 1, 32'hA, 0, 0, 0, 0, 0);
        tick();
        set_ctl(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            rand_mem();
            tick();
            chk("hold_wdata", bus.wb_wdata, 32'hA);
            chk("hold_valid", bus.wb_valid, 1);
        end
        set_ctl(0, 0, 1, 0);
        tick();
        chk("bub_valid", bus.wb_valid, 0);
        chk("bub_wreg", bus.wb_wreg, 0);
        chk("bub_cnt", bus.bubble_cnt, 1);
        set_ctl(0, 0, 0, 0);
        set_mem(1, 5'd9, 1, 32'hB, 0, 0, 0, 0, 0);
        tick();
        chk("b_wdata", bus.wb_wdata, 32'hB);

        // Illegal stall_wb=1/stall_mem=0 must hold
        set_ctl(0, 0, 0, 1);
        set_mem(1, 5'd4, 1, 32'hC0FFEE, 0, 0, 0, 0, 0);
        tick();
        chk("illeg_wdata", bus.wb_wdata, 32'hB);

        // Flush beats stall on a valid entry
        set_ctl(0, 1, 1, 1);
        tick();
        chk("flush_valid", bus.wb_valid, 0);
        chk("flush_wdata", bus.wb_wdata, 0);
        chk("flush_retire", bus.retire_cnt, 4);
        chk("flush_bubble", bus.bubble_cnt, 1);

        // Saturation on the 4-bit copy, then reset
        set_ctl(1, 0, 1, 1);
        tick();
        set_ctl(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            rand_mem();
            bus.mem_valid = 1;
            tick();
        end
        chk("sat_retire4", bus4.retire_cnt, 15);
        chk("sat_retire", bus.retire_cnt, 20);
        set_ctl(1, 0, 0, 0);
        tick();
        chk("sat_rst4", bus4.retire_cnt, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_ctl($urandom_range(0, 49) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0);
            rand_mem();
            if ($urandom_range(0, 5) == 0) bus.mem_wd = 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
